// File: rtl/s_memory_pkg.sv
// Shared widths and reader state encoding for the s_memory fill writer and reader.
package s_memory_pkg;

  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PRESENT,
    DONE
  } rd_state_t;

endpackage

// File: rtl/s_memory_reader.sv
// Sequential s_memory reader: walks 0..2**ADDR_W-1 once per start and streams words on valid/ready.
// Optional identity-fill checker is built when S_MEMORY_READER_CHECK_EN is defined.
module s_memory_reader
  import s_memory_pkg::*;
#(
  parameter int ADDR_W     = S_ADDR_W,
  parameter int DATA_W     = S_DATA_W,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_count,
  output logic              err
);

  // A latency of 1 still needs a 1-bit counter; it simply always sits at zero.
  localparam int                WCNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(RD_LATENCY - 1);

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_busy;
  logic              w_accept;
  logic              w_capture;
  logic              w_handshake;
  logic              w_last;

  assign w_last = (r_mem_addr == '1);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_wcnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = w_last ? DONE : WAIT;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wcnt <= '0;
    end else if (w_accept || (w_handshake && !w_last)) begin
      r_wcnt <= WCNT_LOAD;
    end else if (r_state == WAIT && r_wcnt != '0) begin
      r_wcnt <= r_wcnt - WCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr  <= '0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_mem_addr <= '0;
      end
      if (w_capture) begin
        r_out_data  <= mem_q;
        r_out_addr  <= r_mem_addr;
        r_out_valid <= 1'b1;
      end
      if (w_handshake) begin
        r_out_valid <= 1'b0;
        if (!w_last) r_mem_addr <= r_mem_addr + ADDR_W'(1);
      end
      // Parking the address at 0 keeps it stable ahead of the next pass's first read.
      if (r_state == DONE) begin
        r_busy     <= 1'b0;
        r_mem_addr <= '0;
      end
    end
  end

`ifdef S_MEMORY_READER_CHECK_EN
  logic [ADDR_W:0] r_err_count;
  logic            r_err;
  logic            w_mismatch;

  assign w_mismatch = w_capture && (mem_q != DATA_W'(r_mem_addr));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_err_count <= '0;
      r_err       <= 1'b0;
    end else if (w_mismatch) begin
      if (r_err_count != '1) r_err_count <= r_err_count + (ADDR_W+1)'(1);
      r_err <= 1'b1;
    end
  end

  assign err_count = r_err_count;
  assign err       = r_err;
`else
  assign err_count = '0;
  assign err       = 1'b0;
`endif

  assign mem_addr  = r_mem_addr;
  assign mem_wren  = 1'b0;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign busy      = r_busy;
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_s_memory_reader.sv
// Self-checking bench for s_memory_reader: scoreboarded stream against a RAM model,
// stall, checker, ignored starts, async reset, and latency 1/4 variants.
module tb_s_memory_reader;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          reset_n, start, out_ready;
  logic [AW-1:0] mem_addr, out_addr;
  logic          mem_wren, out_valid, busy, done, err;
  logic [DW-1:0] mem_q, out_data;
  logic [AW:0]   err_count;

  s_memory_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mem_addr(mem_addr), .mem_wren(mem_wren),
    .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .busy(busy), .done(done), .err_count(err_count), .err(err)
  );

  // Latency-2 RAM: one register stage after the array read, sampled by the reader's capture edge.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_q;
  always @(posedge clk) ram_q <= ram[mem_addr];
  assign mem_q = ram_q;

  // Latency 1 and 4 variants on identity memories.
  logic          s_start, s_ready;
  logic [AW-1:0] s1_mem_addr, s1_oaddr, s4_mem_addr, s4_oaddr;
  logic [DW-1:0] s1_mem_q, s1_odata, s4_mem_q, s4_odata;
  logic          s1_wren, s1_valid, s1_busy, s1_done, s1_err;
  logic          s4_wren, s4_valid, s4_busy, s4_done, s4_err;
  logic [AW:0]   s1_errc, s4_errc;
  logic [DW-1:0] p4_0, p4_1, p4_2;

  s_memory_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .start(s_start), .mem_addr(s1_mem_addr), .mem_wren(s1_wren),
    .mem_q(s1_mem_q), .out_valid(s1_valid), .out_ready(s_ready), .out_data(s1_odata),
    .out_addr(s1_oaddr), .busy(s1_busy), .done(s1_done), .err_count(s1_errc), .err(s1_err)
  );
  assign s1_mem_q = s1_mem_addr;

  s_memory_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(4)) dut_l4 (
    .clk(clk), .reset_n(reset_n), .start(s_start), .mem_addr(s4_mem_addr), .mem_wren(s4_wren),
    .mem_q(s4_mem_q), .out_valid(s4_valid), .out_ready(s_ready), .out_data(s4_odata),
    .out_addr(s4_oaddr), .busy(s4_busy), .done(s4_done), .err_count(s4_errc), .err(s4_err)
  );
  always @(posedge clk) begin
    p4_0 <= s4_mem_addr;
    p4_1 <= p4_0;
    p4_2 <= p4_1;
  end
  assign s4_mem_q = p4_2;

  int errors = 0;
  int checks = 0;

  logic [15:0] sb_q [$];
  logic [15:0] sb_exp;
  bit          mon_en = 1'b0;
  bit          wren_bad = 1'b0;
  int          hs_count = 0;
  int          done_count = 0;

  always @(negedge clk) begin
    if (mem_wren !== 1'b0 || s1_wren !== 1'b0 || s4_wren !== 1'b0) wren_bad = 1'b1;
    if (reset_n && mon_en) begin
      if (done) done_count++;
      if (out_valid && out_ready) begin
        hs_count++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got addr=%h data=%h, no word expected", out_addr, out_data);
        end else begin
          sb_exp = sb_q.pop_front();
          if ({out_addr, out_data} !== sb_exp) begin
            errors++;
            $display("FAIL sb_word: got addr=%h data=%h, expected addr=%h data=%h",
                     out_addr, out_data, sb_exp[15:8], sb_exp[7:0]);
          end
        end
      end
    end
  end

  task automatic push_pass();
    for (int a = 0; a < 256; a++) sb_q.push_back({8'(a), ram[a]});
    hs_count   = 0;
    done_count = 0;
  endtask

  task automatic pulse_start(output int e0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_valid(input int want_addr, output int t);
    t = -1;
    for (int i = 0; i < 2000; i++) begin
      if (out_valid && (want_addr < 0 || int'(out_addr) == want_addr)) begin
        t = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int a = 0; a < 256; a++) ram[a] = 8'(a);
    reset_n = 1'b0; start = 1'b0; out_ready = 1'b0; s_start = 1'b0; s_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({mem_addr, out_valid, out_data, out_addr, busy, done, err_count, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h v=%b d=%h oa=%h busy=%b done=%b ec=%h err=%b, expected all 0",
               mem_addr, out_valid, out_data, out_addr, busy, done, err_count, err);
    end
    checks++;
    if (mem_wren !== 1'b0) begin
      errors++;
      $display("FAIL reset_wren: got %b, expected 0", mem_wren);
    end
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, out_valid, mem_addr} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b v=%b addr=%h, expected 0 0 00", busy, out_valid, mem_addr);
    end
  endtask

  task automatic test_stream();
    int e0, tv, td;
    push_pass();
    wren_bad  = 1'b0;
    out_ready = 1'b1;
    pulse_start(e0);
    wait_valid(-1, tv);
    checks++;
    if (tv - e0 !== 2) begin
      errors++;
      $display("FAIL first_valid_latency: got %0d, expected 2", tv - e0);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_pass: got %b, expected 1", busy);
    end
    wait_done(td);
    checks++;
    if (td - e0 !== 768) begin
      errors++;
      $display("FAIL stream_done_time: got %0d, expected 768", td - e0);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, out_valid, mem_addr} !== '0) begin
      errors++;
      $display("FAIL after_done: got busy=%b done=%b v=%b addr=%h, expected 0 0 0 00", busy, done, out_valid, mem_addr);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_count !== 1 || hs_count !== 256 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL stream_totals: got done=%0d words=%0d left=%0d, expected 1 256 0", done_count, hs_count, sb_q.size());
    end
    checks++;
    if (wren_bad !== 1'b0) begin
      errors++;
      $display("FAIL wren_const: got a nonzero mem_wren, expected 0 throughout");
    end
  endtask

  task automatic test_stall();
    int e0, tv, td;
    push_pass();
    out_ready = 1'b1;
    pulse_start(e0);
    wait_valid(8'h10, tv);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 || out_addr !== 8'h10 || mem_addr !== 8'h10) begin
        errors++;
        $display("FAIL stall_hold: got v=%b d=%h oa=%h ma=%h, expected 1 10 10 10", out_valid, out_data, out_addr, mem_addr);
      end
    end
    out_ready = 1'b1;
    wait_done(td);
    checks++;
    if (td - e0 !== 773) begin
      errors++;
      $display("FAIL stall_done_time: got %0d, expected 773", td - e0);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hs_count !== 256 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL stall_totals: got words=%0d left=%0d, expected 256 0", hs_count, sb_q.size());
    end
  endtask

  task automatic test_check();
    int e0, td;
    logic [AW:0] exp_cnt;
    logic        exp_err;
`ifdef S_MEMORY_READER_CHECK_EN
    exp_cnt = 9'd1;
    exp_err = 1'b1;
`else
    exp_cnt = 9'd0;
    exp_err = 1'b0;
`endif
    ram[8'h37] = 8'hFF;
    push_pass();
    out_ready = 1'b1;
    pulse_start(e0);
    wait_done(td);
    @(posedge clk); #1;
    checks++;
    if (err !== exp_err || err_count !== exp_cnt) begin
      errors++;
      $display("FAIL check_result: got err=%b count=%0d, expected err=%b count=%0d", err, err_count, exp_err, exp_cnt);
    end
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL check_stream: got %0d words left, expected 0", sb_q.size());
    end
    ram[8'h37] = 8'h37;
    pulse_start(e0);
    checks++;
    if (err !== 1'b0 || err_count !== '0) begin
      errors++;
      $display("FAIL check_clear: got err=%b count=%0d, expected 0 0", err, err_count);
    end
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_ignore_start();
    int e0, tv, td;
    push_pass();
    out_ready = 1'b1;
    pulse_start(e0);
    wait_valid(8'h40, tv);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_mid_busy: got %b, expected 1", busy);
    end
    wait_done(td);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done_cycle: got busy=%b done=%b, expected 0 0", busy, done);
    end
    checks++;
    if (td - e0 !== 768) begin
      errors++;
      $display("FAIL ignore_done_time: got %0d, expected 768", td - e0);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done_count !== 1 || hs_count !== 256 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL ignore_no_pass: got busy=%b v=%b done=%0d words=%0d left=%0d, expected 0 0 1 256 0",
               busy, out_valid, done_count, hs_count, sb_q.size());
    end
  endtask

  task automatic test_async_reset();
    int e0, tv, td;
    push_pass();
    out_ready = 1'b1;
    pulse_start(e0);
    wait_valid(8'h80, tv);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_addr, out_valid, out_data, out_addr, busy, done, err_count, err} !== '0) begin
      errors++;
      $display("FAIL async_reset: got addr=%h v=%b d=%h oa=%h busy=%b done=%b ec=%h err=%b, expected all 0",
               mem_addr, out_valid, out_data, out_addr, busy, done, err_count, err);
    end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    push_pass();
    pulse_start(e0);
    wait_valid(-1, tv);
    checks++;
    if (tv - e0 !== 2 || out_addr !== 8'h00) begin
      errors++;
      $display("FAIL restart_first: got latency=%0d addr=%h, expected 2 00", tv - e0, out_addr);
    end
    wait_done(td);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (td - e0 !== 768 || hs_count !== 256 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL restart_pass: got time=%0d words=%0d left=%0d, expected 768 256 0", td - e0, hs_count, sb_q.size());
    end
  endtask

  task automatic test_latency();
    int e0, f1, f4, d1, d4, w1, w4, bad1, bad4;
    f1 = -1; f4 = -1; d1 = -1; d4 = -1; w1 = 0; w4 = 0; bad1 = 0; bad4 = 0;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    e0 = cyc;
    for (int i = 0; i < 1400 && (d1 < 0 || d4 < 0); i++) begin
      @(posedge clk); #1;
      if (s1_valid) begin
        if (f1 < 0) f1 = cyc - e0;
        if (s1_odata !== 8'(w1) || s1_oaddr !== 8'(w1)) bad1++;
        w1++;
      end
      if (s4_valid) begin
        if (f4 < 0) f4 = cyc - e0;
        if (s4_odata !== 8'(w4) || s4_oaddr !== 8'(w4)) bad4++;
        w4++;
      end
      if (s1_done && d1 < 0) d1 = cyc - e0;
      if (s4_done && d4 < 0) d4 = cyc - e0;
    end
    checks++;
    if (f1 !== 1 || f4 !== 4) begin
      errors++;
      $display("FAIL latency_first: got L1=%0d L4=%0d, expected 1 4", f1, f4);
    end
    checks++;
    if (d1 !== 512 || d4 !== 1280) begin
      errors++;
      $display("FAIL latency_done_time: got L1=%0d L4=%0d, expected 512 1280", d1, d4);
    end
    checks++;
    if (w1 !== 256 || bad1 !== 0 || w4 !== 256 || bad4 !== 0) begin
      errors++;
      $display("FAIL latency_data: got L1 words=%0d bad=%0d L4 words=%0d bad=%0d, expected 256 0 256 0",
               w1, bad1, w4, bad4);
    end
    @(posedge clk); #1;
    checks++;
    if ({s1_busy, s4_busy, s1_err, s4_err, s1_errc, s4_errc} !== '0 || wren_bad !== 1'b0) begin
      errors++;
      $display("FAIL latency_idle: got busy=%b%b err=%b%b ec=%0d/%0d wren_bad=%b, expected all 0",
               s1_busy, s4_busy, s1_err, s4_err, s1_errc, s4_errc, wren_bad);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_check();
    test_ignore_start();
    test_async_reset();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
